// File: rtl/alu_issue_pkg.sv
// Shared RV64I issue-stage constants: opcodes, ALU function groups and the registered command layout.
// The ALU and alu32 use the same funct constants.
package alu_issue_pkg;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;

    localparam logic [6:0] OPCODE_OP        = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
    localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;

    localparam logic [2:0] ALU_ADD_SUB = 3'b000;
    localparam logic [2:0] ALU_SLL     = 3'b001;
    localparam logic [2:0] ALU_SLT     = 3'b010;
    localparam logic [2:0] ALU_SLTU    = 3'b011;
    localparam logic [2:0] ALU_XOR     = 3'b100;
    localparam logic [2:0] ALU_SHIFTR  = 3'b101;
    localparam logic [2:0] ALU_OR      = 3'b110;
    localparam logic [2:0] ALU_AND     = 3'b111;

    typedef struct packed {
        logic [3:0]      funct;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic            is_word_op;
        logic [4:0]      rd;
        logic            illegal;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction/operand request from register read and the ALU command toward EX.
// master is the issue stage's view, slave is the surrounding pipeline's view.
interface alu_issue_if;

    logic                             in_valid;
    logic                             in_ready;
    logic [31:0]                      instruction;
    logic [alu_issue_pkg::ADDR_W-1:0] pc;
    logic [alu_issue_pkg::XLEN-1:0]   rs1_data;
    logic [alu_issue_pkg::XLEN-1:0]   rs2_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [3:0]                       alu_funct;
    logic [alu_issue_pkg::XLEN-1:0]   operand_a;
    logic [alu_issue_pkg::XLEN-1:0]   operand_b;
    logic                             is_word_op;
    logic [4:0]                       rd;
    logic                             illegal;

    modport master (
        input  in_valid, instruction, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_funct, operand_a, operand_b, is_word_op, rd, illegal
    );

    modport slave (
        output in_valid, instruction, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_funct, operand_a, operand_b, is_word_op, rd, illegal
    );

endinterface

// File: rtl/alu_issue_stage_skid_buffer2.sv
// Two-entry skid buffer: main entry drives the outputs, skid entry absorbs the one command that
// arrives while the consumer stalls, so in_ready can be a register without losing throughput.
module skid_buffer2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

    skid_state_t      state;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Flush keeps the stale payload but it is never presented because out_valid drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// RV64I integer issue stage: decodes an instruction into an ALU command (funct, operands,
// word-op flag, rd, illegal) and hands it to the ALU through a two-entry skid buffer.
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input logic         clock,
    input logic         reset,
    input logic         flush,
    alu_issue_if.master bus
);

    alu_cmd_t   dec;
    alu_cmd_t   cmd;
    logic       legal;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift;

    assign opcode   = bus.instruction[6:0];
    assign funct3   = bus.instruction[14:12];
    assign funct7   = bus.instruction[31:25];
    assign is_shift = (funct3 == ALU_SLL) || (funct3 == ALU_SHIFTR);

    // Anything not explicitly legal collapses to an ADD of zeros so the ALU never sees garbage.
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OPCODE_OP, OPCODE_OP_32: begin
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == ALU_ADD_SUB || funct3 == ALU_SHIFTR));
                if (opcode == OPCODE_OP_32 && !(funct3 == ALU_ADD_SUB || is_shift)) begin
                    legal = 1'b0;
                end
                dec.funct      = {bus.instruction[30], funct3};
                dec.operand_a  = bus.rs1_data;
                dec.operand_b  = bus.rs2_data;
                dec.is_word_op = (opcode == OPCODE_OP_32);
            end
            OPCODE_OP_IMM, OPCODE_OP_IMM_32: begin
                legal          = 1'b1;
                dec.is_word_op = (opcode == OPCODE_OP_IMM_32);
                dec.funct      = {1'b0, funct3};
                dec.operand_a  = bus.rs1_data;
                dec.operand_b  = sext12(bus.instruction[31:20]);
                if (dec.is_word_op && !(funct3 == ALU_ADD_SUB || is_shift)) begin
                    legal = 1'b0;
                end
                if (is_shift) begin
                    legal = legal && (bus.instruction[31:26] == 6'b000000 ||
                                      bus.instruction[31:26] == 6'b010000);
                    if (funct3 == ALU_SHIFTR) begin
                        dec.funct[3] = bus.instruction[30];
                    end
                    if (dec.is_word_op) begin
                        legal         = legal && !bus.instruction[25];
                        dec.operand_b = {{(XLEN-5){1'b0}}, bus.instruction[24:20]};
                    end else begin
                        dec.operand_b = {{(XLEN-6){1'b0}}, bus.instruction[25:20]};
                    end
                end
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                legal         = 1'b1;
                dec.funct     = {1'b0, ALU_ADD_SUB};
                dec.operand_a = (opcode == OPCODE_AUIPC) ? bus.pc : '0;
                dec.operand_b = {{(XLEN-32){bus.instruction[31]}}, bus.instruction[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.funct      = {1'b0, ALU_ADD_SUB};
            dec.operand_a  = '0;
            dec.operand_b  = '0;
            dec.is_word_op = 1'b0;
        end
        dec.rd      = bus.instruction[11:7];
        dec.illegal = !legal;
    end

    skid_buffer2 #(
        .WIDTH (CMD_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (cmd)
    );

    assign bus.alu_funct  = cmd.funct;
    assign bus.operand_a  = cmd.operand_a;
    assign bus.operand_b  = cmd.operand_b;
    assign bus.is_word_op = cmd.is_word_op;
    assign bus.rd         = cmd.rd;
    assign bus.illegal    = cmd.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected commands are queued on accept and compared
// when the stage hands a command to the ALU.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic clock;
    logic reset;
    logic flush;
    logic rand_mode;
    int   checks;
    int   errors;

    alu_cmd_t drive_exp;
    alu_cmd_t sb[$];

    alu_issue_if bus ();

    alu_issue_stage dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic alu_cmd_t mk(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                    input logic w, input logic [4:0] r, input logic ill);
        alu_cmd_t c;
        c.funct      = f;
        c.operand_a  = a;
        c.operand_b  = b;
        c.is_word_op = w;
        c.rd         = r;
        c.illegal    = ill;
        return c;
    endfunction

    // Sampled mid-cycle: what is seen here is what the next rising edge will act on.
    always @(negedge clock) begin
        alu_cmd_t e;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_output("stale_cmd", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("alu_funct",  {60'd0, bus.alu_funct}, {60'd0, e.funct});
                    check_output("operand_a",  bus.operand_a, e.operand_a);
                    check_output("operand_b",  bus.operand_b, e.operand_b);
                    check_output("is_word_op", {63'd0, bus.is_word_op}, {63'd0, e.is_word_op});
                    check_output("rd",         {59'd0, bus.rd}, {59'd0, e.rd});
                    check_output("illegal",    {63'd0, bus.illegal}, {63'd0, e.illegal});
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(drive_exp);
        end
    end

    task automatic apply_stimulus(input logic [31:0] ins, input logic [63:0] p, input logic [63:0] r1,
                                  input logic [63:0] r2, input alu_cmd_t exp);
        int waited = 0;
        bus.instruction = ins;
        bus.pc          = p;
        bus.rs1_data    = r1;
        bus.rs2_data    = r2;
        drive_exp       = exp;
        bus.in_valid    = 1'b1;
        if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        while (!bus.in_ready && waited < 50) begin
            @(posedge clock);
            #1;
            if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
            waited++;
            @(negedge clock);
        end
        if (!bus.in_ready) check_output("accept_timeout", 64'd0, 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [4:0]  rdf;
        logic [11:0] imm;
        logic [63:0] r1;
        logic [63:0] r2;
        checks          = 0;
        errors          = 0;
        rand_mode       = 1'b0;
        reset           = 1'b1;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.instruction = '0;
        bus.pc          = '0;
        bus.rs1_data    = '0;
        bus.rs2_data    = '0;
        drive_exp       = '0;

        repeat (2) @(negedge clock);
        check_output("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_output("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        check_output("rst_funct",     {60'd0, bus.alu_funct}, 64'd0);
        check_output("rst_operand_a", bus.operand_a, 64'd0);
        check_output("rst_operand_b", bus.operand_b, 64'd0);
        check_output("rst_word",      {63'd0, bus.is_word_op}, 64'd0);
        check_output("rst_rd",        {59'd0, bus.rd}, 64'd0);
        check_output("rst_illegal",   {63'd0, bus.illegal}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Directed decode cases with hand-derived expectations.
        apply_stimulus({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 64'h0, 64'd5, 64'd7,
                       mk(4'h0, 64'd5, 64'd7, 1'b0, 5'd3, 1'b0));
        apply_stimulus({7'b0100000, 5'd31, 5'd6, 3'b101, 5'd5, 7'b0011011}, 64'h0, 64'h8000_0000, 64'd0,
                       mk(4'hD, 64'h8000_0000, 64'd31, 1'b1, 5'd5, 1'b0));
        apply_stimulus({7'b0100001, 5'd31, 5'd6, 3'b101, 5'd5, 7'b0011011}, 64'h0, 64'h8000_0000, 64'd0,
                       mk(4'h0, 64'd0, 64'd0, 1'b0, 5'd5, 1'b1));
        apply_stimulus({12'hFFF, 5'd1, 3'b000, 5'd4, 7'b0010011}, 64'h0, 64'd10, 64'd0,
                       mk(4'h0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd4, 1'b0));
        apply_stimulus({20'h12345, 5'd7, 7'b0010111}, 64'h1000, 64'd0, 64'd0,
                       mk(4'h0, 64'h1000, 64'h1234_5000, 1'b0, 5'd7, 1'b0));
        apply_stimulus({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011}, 64'h0, 64'd20, 64'd7,
                       mk(4'h8, 64'd20, 64'd7, 1'b0, 5'd8, 1'b0));
        apply_stimulus({20'h80000, 5'd9, 7'b0110111}, 64'h4000, 64'd3, 64'd0,
                       mk(4'h0, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd9, 1'b0));
        apply_stimulus({20'h0, 5'd10, 7'b1100011}, 64'h0, 64'd1, 64'd2,
                       mk(4'h0, 64'd0, 64'd0, 1'b0, 5'd10, 1'b1));
        apply_stimulus({7'b0100000, 5'd2, 5'd1, 3'b001, 5'd11, 7'b0111011}, 64'h0, 64'd1, 64'd2,
                       mk(4'h0, 64'd0, 64'd0, 1'b0, 5'd11, 1'b1));
        apply_stimulus({7'b0000000, 5'd2, 5'd1, 3'b010, 5'd12, 7'b0111011}, 64'h0, 64'd1, 64'd2,
                       mk(4'h0, 64'd0, 64'd0, 1'b0, 5'd12, 1'b1));
        apply_stimulus({6'b000000, 6'd63, 5'd1, 3'b001, 5'd13, 7'b0010011}, 64'h0, 64'd1, 64'd0,
                       mk(4'h1, 64'd1, 64'd63, 1'b0, 5'd13, 1'b0));
        apply_stimulus({7'b0100000, 5'd3, 5'd1, 3'b101, 5'd14, 7'b0111011}, 64'h0, 64'hF0, 64'd3,
                       mk(4'hD, 64'hF0, 64'd3, 1'b1, 5'd14, 1'b0));
        idle(3);

        // Backpressure: two commands fit, the third is refused and outputs hold.
        bus.out_ready = 1'b0;
        apply_stimulus({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd15, 7'b0110011}, 64'h0, 64'd100, 64'd1,
                       mk(4'h0, 64'd100, 64'd1, 1'b0, 5'd15, 1'b0));
        apply_stimulus({7'b0000000, 5'd2, 5'd1, 3'b100, 5'd16, 7'b0110011}, 64'h0, 64'd200, 64'd2,
                       mk(4'h4, 64'd200, 64'd2, 1'b0, 5'd16, 1'b0));
        bus.instruction = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd17, 7'b0110011};
        bus.rs1_data    = 64'd300;
        drive_exp       = mk(4'h7, 64'd300, 64'd3, 1'b0, 5'd17, 1'b0);
        bus.in_valid    = 1'b1;
        @(negedge clock);
        check_output("bp_in_ready",  {63'd0, bus.in_ready}, 64'd0);
        check_output("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        repeat (2) @(negedge clock);
        check_output("bp_hold_a",  bus.operand_a, 64'd100);
        check_output("bp_hold_rd", {59'd0, bus.rd}, 64'd15);
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        check_output("bp_drained", 64'(sb.size()), 64'd0);

        // Flush while both entries are full.
        bus.out_ready = 1'b0;
        apply_stimulus({12'd1, 5'd1, 3'b000, 5'd18, 7'b0010011}, 64'h0, 64'd1, 64'd0,
                       mk(4'h0, 64'd1, 64'd1, 1'b0, 5'd18, 1'b0));
        apply_stimulus({12'd2, 5'd1, 3'b000, 5'd19, 7'b0010011}, 64'h0, 64'd1, 64'd0,
                       mk(4'h0, 64'd1, 64'd2, 1'b0, 5'd19, 1'b0));
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check_output("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_output("flush_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        idle(3);

        // An instruction offered in the flush cycle is dropped.
        bus.instruction = {12'd5, 5'd1, 3'b000, 5'd20, 7'b0010011};
        bus.in_valid    = 1'b1;
        flush           = 1'b1;
        @(posedge clock);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check_output("flush_drop", {63'd0, bus.out_valid}, 64'd0);
        idle(3);

        // Asynchronous reset in the middle of traffic.
        bus.out_ready = 1'b0;
        apply_stimulus({12'd7, 5'd1, 3'b000, 5'd21, 7'b0010011}, 64'h0, 64'd9, 64'd0,
                       mk(4'h0, 64'd9, 64'd7, 1'b0, 5'd21, 1'b0));
        apply_stimulus({12'd8, 5'd1, 3'b000, 5'd22, 7'b0010011}, 64'h0, 64'd9, 64'd0,
                       mk(4'h0, 64'd9, 64'd8, 1'b0, 5'd22, 1'b0));
        #2 reset = 1'b1;
        #1;
        check_output("mrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_output("mrst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        check_output("mrst_operand_a", bus.operand_a, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);

        // Random ADD/ADDI traffic with a randomly stalling consumer.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdf = 5'($urandom_range(0, 31));
            r1  = {$urandom, $urandom};
            r2  = {$urandom, $urandom};
            imm = 12'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                apply_stimulus({7'b0000000, 5'd2, 5'd1, 3'b000, rdf, 7'b0110011}, 64'h0, r1, r2,
                               mk(4'h0, r1, r2, 1'b0, rdf, 1'b0));
            end else begin
                apply_stimulus({imm, 5'd1, 3'b000, rdf, 7'b0010011}, 64'h0, r1, r2,
                               mk(4'h0, r1, {{52{imm[11]}}, imm}, 1'b0, rdf, 1'b0));
            end
        end
        rand_mode     = 1'b0;
        bus.out_ready = 1'b1;
        idle(5);
        check_output("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
